// File: rtl/synth_pkg.sv
// Shared constants and the envelope state encoding for the synth voice blocks.
package synth_pkg;

  localparam int NBITS    = 10;
  localparam int CLKSPEED = 100_000_000;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } adsr_state_t;

endpackage

// File: rtl/tick_gen.sv
// Free-running rate divider: tick is high for one clk every PRESCALE cycles; clr restarts the count.
module tick_gen #(
  parameter int PRESCALE = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] count_r;

  // Prescale counter: wraps at LAST, restarts on clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CW{1'b0}};
    end else if (clr || (count_r == LAST)) begin
      count_r <= {CW{1'b0}};
    end else begin
      count_r <= count_r + CW'(1'b1);
    end
  end

  assign tick = (count_r == LAST);

endmodule

// File: rtl/adsr_env.sv
// ADSR envelope controller: gate-driven state machine stepping a saturating amplitude level
// on prescaled ticks.
module adsr_env
  import synth_pkg::*;
#(
  parameter int NBITS    = synth_pkg::NBITS,
  parameter int PRESCALE = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             gate,
  input  logic [NBITS-1:0] attack_step,
  input  logic [NBITS-1:0] decay_step,
  input  logic [NBITS-1:0] sustain_level,
  input  logic [NBITS-1:0] release_step,
  output logic [NBITS-1:0] amp,
  output logic [2:0]       state,
  output logic             busy,
  output logic             done
);

  localparam logic [NBITS-1:0] MAX  = {NBITS{1'b1}};
  localparam logic [NBITS-1:0] ZERO = {NBITS{1'b0}};

  adsr_state_t      state_r;
  logic [NBITS-1:0] amp_r;
  logic             gate_q_r;
  logic             armed_r;
  logic             busy_r;
  logic             done_r;
  logic             rise_s;
  logic             fall_s;
  logic             edge_s;
  logic             tick_s;
  logic [NBITS:0]   att_sum_s;
  logic [NBITS:0]   dec_lim_s;

  // Edge detection and widened arithmetic for the saturating steps.
  // armed_r masks the first cycle after reset so a gate already held high is not seen as a new note.
  always_comb begin
    rise_s    = 1'b0;
    fall_s    = 1'b0;
    att_sum_s = {1'b0, amp_r} + {1'b0, attack_step};
    dec_lim_s = {1'b0, sustain_level} + {1'b0, decay_step};
    if (armed_r) begin
      rise_s = gate & ~gate_q_r;
      fall_s = ~gate & gate_q_r &
               ((state_r == ST_ATTACK) || (state_r == ST_DECAY) || (state_r == ST_SUSTAIN));
    end else begin
      rise_s = 1'b0;
      fall_s = 1'b0;
    end
    edge_s = rise_s | fall_s;
  end

  tick_gen #(.PRESCALE(PRESCALE)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (edge_s),
    .tick (tick_s)
  );

  // Envelope FSM with registered level, busy and done outputs; edges take priority over ticks
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= ST_IDLE;
      amp_r    <= ZERO;
      gate_q_r <= 1'b0;
      armed_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      gate_q_r <= gate;
      armed_r  <= 1'b1;
      done_r   <= 1'b0;
      if (rise_s) begin
        state_r <= ST_ATTACK;
        busy_r  <= 1'b1;
      end else if (fall_s) begin
        state_r <= ST_RELEASE;
        busy_r  <= 1'b1;
      end else if (tick_s) begin
        case (state_r)
          ST_IDLE: begin
            amp_r  <= ZERO;
            busy_r <= 1'b0;
          end
          ST_ATTACK: begin
            if ((attack_step == ZERO) || (att_sum_s >= {1'b0, MAX})) begin
              amp_r   <= MAX;
              state_r <= ST_DECAY;
            end else begin
              amp_r <= att_sum_s[NBITS-1:0];
            end
          end
          ST_DECAY: begin
            if ((decay_step == ZERO) || ({1'b0, amp_r} <= dec_lim_s)) begin
              amp_r   <= sustain_level;
              state_r <= ST_SUSTAIN;
            end else begin
              amp_r <= amp_r - decay_step;
            end
          end
          ST_SUSTAIN: begin
            amp_r <= sustain_level;
          end
          ST_RELEASE: begin
            if ((release_step == ZERO) || (amp_r <= release_step)) begin
              amp_r   <= ZERO;
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              amp_r <= amp_r - release_step;
            end
          end
          default: begin
            amp_r   <= ZERO;
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

  assign amp   = amp_r;
  assign state = state_r;
  assign busy  = busy_r;
  assign done  = done_r;

endmodule

// File: tb/tb_adsr_env.sv
// Directed self-checking bench for adsr_env with a 4-cycle tick prescaler.
module tb_adsr_env;

  logic       clk;
  logic       rst_n;
  logic       gate;
  logic [9:0] attack_step;
  logic [9:0] decay_step;
  logic [9:0] sustain_level;
  logic [9:0] release_step;
  logic [9:0] amp;
  logic [2:0] state;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  int att_amp[4] = '{256, 512, 768, 1023};
  int att_st[4]  = '{1, 1, 1, 2};
  int dec_amp[5] = '{923, 823, 723, 623, 600};
  int dec_st[5]  = '{2, 2, 2, 2, 3};

  adsr_env #(.NBITS(10), .PRESCALE(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .gate         (gate),
    .attack_step  (attack_step),
    .decay_step   (decay_step),
    .sustain_level(sustain_level),
    .release_step (release_step),
    .amp          (amp),
    .state        (state),
    .busy         (busy),
    .done         (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input int e_amp, input int e_st, input int e_busy,
                         input int e_done);
    chk({tag, ".amp"},   32'(amp),   32'(e_amp));
    chk({tag, ".state"}, 32'(state), 32'(e_st));
    chk({tag, ".busy"},  32'(busy),  32'(e_busy));
    chk({tag, ".done"},  32'(done),  32'(e_done));
  endtask

  initial begin
    rst_n         = 1'b0;
    gate          = 1'b0;
    attack_step   = 10'd256;
    decay_step    = 10'd100;
    sustain_level = 10'd600;
    release_step  = 10'd200;
    #2;
    chk_all("reset", 0, 0, 0, 0);
    step(1);
    rst_n = 1'b1;
    step(2);

    // Full attack/decay to sustain
    gate = 1'b1;
    step(1);
    chk_all("rise", 0, 1, 1, 0);
    for (int i = 0; i < 4; i++) begin
      step(4);
      chk_all($sformatf("attack%0d", i), att_amp[i], att_st[i], 1, 0);
    end
    for (int i = 0; i < 5; i++) begin
      step(4);
      chk_all($sformatf("decay%0d", i), dec_amp[i], dec_st[i], 1, 0);
    end

    // Release from 600 by 200
    gate = 1'b0;
    step(1);
    chk_all("fall", 600, 4, 1, 0);
    step(3);
    chk_all("rel_pre", 600, 4, 1, 0);
    step(1);
    chk_all("rel0", 400, 4, 1, 0);
    step(4);
    chk_all("rel1", 200, 4, 1, 0);
    step(4);
    chk_all("rel_end", 0, 0, 0, 1);
    step(1);
    chk_all("done_pulse", 0, 0, 0, 0);

    // Retrigger during release continues from 400
    gate = 1'b1;
    step(37);
    chk_all("sus_again", 600, 3, 1, 0);
    gate = 1'b0;
    step(5);
    chk_all("retrig_rel", 400, 4, 1, 0);
    gate = 1'b1;
    step(1);
    chk_all("retrig_rise", 400, 1, 1, 0);
    step(4);
    chk_all("retrig_att", 656, 1, 1, 0);

    // Instant release, then instant attack/decay/release
    gate = 1'b0;
    release_step = 10'd0;
    step(5);
    chk_all("inst_rel0", 0, 0, 0, 1);
    attack_step   = 10'd0;
    decay_step    = 10'd0;
    sustain_level = 10'd300;
    gate = 1'b1;
    step(5);
    chk_all("inst_att", 1023, 2, 1, 0);
    step(4);
    chk_all("inst_dec", 300, 3, 1, 0);
    gate = 1'b0;
    step(5);
    chk_all("inst_rel", 0, 0, 0, 1);

    // Gate rise colliding with a release tick
    attack_step   = 10'd256;
    decay_step    = 10'd100;
    sustain_level = 10'd600;
    release_step  = 10'd200;
    gate = 1'b1;
    step(37);
    chk_all("coll_sus", 600, 3, 1, 0);
    gate = 1'b0;
    step(4);
    gate = 1'b1;
    step(1);
    chk_all("coll_edge", 600, 1, 1, 0);
    step(3);
    chk_all("coll_wait", 600, 1, 1, 0);
    step(1);
    chk_all("coll_step", 856, 1, 1, 0);

    // Asynchronous reset mid-decay
    gate = 1'b0;
    release_step = 10'd0;
    step(5);
    chk_all("pre_rst_idle", 0, 0, 0, 1);
    gate = 1'b1;
    step(25);
    chk_all("rst_dec", 823, 2, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 0, 0, 0, 0);
    step(2);
    rst_n = 1'b1;
    step(10);
    chk_all("held_gate", 0, 0, 0, 0);
    gate = 1'b0;
    step(2);
    gate = 1'b1;
    step(1);
    chk_all("rearm_rise", 0, 1, 1, 0);
    step(4);
    chk_all("rearm_att", 256, 1, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
